// File: rtl/call_dispatcher.sv
// Sequences one eBPF CALL into the helper call handler: latches the helper ID and
// arguments, holds a strobe until the handler acks or a timeout expires, then reports R0 or a fault.
module call_dispatcher #(
    parameter int TIMEOUT = 16,
    parameter int TW      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] imm,
    input  logic [63:0] r1,
    input  logic [63:0] r2,
    input  logic [63:0] r3,
    input  logic [63:0] r4,
    input  logic [63:0] r5,
    output logic [63:0] func,
    output logic [63:0] a1,
    output logic [63:0] a2,
    output logic [63:0] a3,
    output logic [63:0] a4,
    output logic [63:0] a5,
    output logic        stb,
    input  logic [63:0] ret,
    input  logic        ack,
    input  logic        err,
    output logic        busy,
    output logic        done,
    output logic        r0_we,
    output logic [63:0] r0_out,
    output logic        fault,
    output logic [1:0]  fault_code
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] CODE_NONE    = 2'd0;
    localparam logic [1:0] CODE_HANDLER = 2'd1;
    localparam logic [1:0] CODE_TIMEOUT = 2'd2;

    state_t        state;
    logic [TW-1:0] timer;

    // Strobe drops in the ack cycle itself so a multi-cycle helper never sees a second request.
    assign busy = (state == S_WAIT);
    assign stb  = busy && !ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            timer      <= '0;
            func       <= '0;
            a1         <= '0;
            a2         <= '0;
            a3         <= '0;
            a4         <= '0;
            a5         <= '0;
            r0_out     <= '0;
            done       <= 1'b0;
            r0_we      <= 1'b0;
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
        end else begin
            done  <= 1'b0;
            r0_we <= 1'b0;
            fault <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        func  <= {32'h0, imm};
                        a1    <= r1;
                        a2    <= r2;
                        a3    <= r3;
                        a4    <= r4;
                        a5    <= r5;
                        timer <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // An ack always beats a timeout landing on the same edge.
                    if (ack) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                        if (err) begin
                            fault      <= 1'b1;
                            fault_code <= CODE_HANDLER;
                        end else begin
                            r0_out     <= ret;
                            r0_we      <= 1'b1;
                            fault_code <= CODE_NONE;
                        end
                    end else if (timer == TIMER_LAST) begin
                        done       <= 1'b1;
                        fault      <= 1'b1;
                        fault_code <= CODE_TIMEOUT;
                        state      <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_call_dispatcher.sv
// Scoreboard bench for call_dispatcher: stimulus pushes expected completions, a
// negedge monitor pops and compares them whenever done appears.
module tb_call_dispatcher;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] imm = '0;
    logic [63:0] r1 = '0, r2 = '0, r3 = '0, r4 = '0, r5 = '0;
    logic [63:0] func, a1, a2, a3, a4, a5;
    logic        stb;
    logic [63:0] ret = '0;
    logic        ack = 1'b0;
    logic        err = 1'b0;
    logic        busy, done, r0_we, fault;
    logic [63:0] r0_out;
    logic [1:0]  fault_code;

    typedef struct {
        logic        fault;
        logic [1:0]  code;
        logic        we;
        logic [63:0] r0;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad = 0;

    call_dispatcher #(.TIMEOUT(16), .TW(16)) dut (
        .clk(clk), .rst(rst), .start(start), .imm(imm),
        .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5),
        .func(func), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5),
        .stb(stb), .ret(ret), .ack(ack), .err(err),
        .busy(busy), .done(done), .r0_we(r0_we), .r0_out(r0_out),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (done || r0_we || fault)) begin
            if (!done) begin
                checkOutput("pulse_without_done", {63'h0, done}, 64'h1);
            end else if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done: got done=1 expected no completion");
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("done_fault", {63'h0, fault}, {63'h0, e.fault});
                checkOutput("done_fault_code", {62'h0, fault_code}, {62'h0, e.code});
                checkOutput("done_r0_we", {63'h0, r0_we}, {63'h0, e.we});
                checkOutput("done_r0_out", r0_out, e.r0);
                checkOutput("done_busy_low", {63'h0, busy}, 64'h0);
            end
        end
        if (!rst && ack) checkOutput("stb_low_during_ack", {63'h0, stb}, 64'h0);
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issues one call; the handler holds off for w strobe cycles, then acks.
    // Returns at the negedge of the done cycle so a following call can start back-to-back.
    task automatic applyStimulus(input logic [31:0] immv, input logic [63:0] r1v, input logic [63:0] r2v,
                                 input int w, input logic ackErr, input logic [63:0] retv,
                                 input logic expFault, input logic [1:0] expCode, input logic expWe,
                                 input logic [63:0] expR0, input bit pokeStart);
        exp_t e;
        int stbCnt;
        e.fault = expFault;
        e.code  = expCode;
        e.we    = expWe;
        e.r0    = expR0;
        expQ.push_back(e);
        imm = immv; r1 = r1v; r2 = r2v; r3 = r1v + 64'd1; r4 = r1v + 64'd2; r5 = r1v + 64'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("func_latch", func, {32'h0, immv});
        checkOutput("a1_latch", a1, r1v);
        checkOutput("a2_latch", a2, r2v);
        checkOutput("a5_latch", a5, r1v + 64'd3);
        stbCnt = 0;
        for (int i = 0; i < w; i++) begin
            if (pokeStart && i == 0) begin
                start = 1'b1;
                imm = 32'h99;
            end
            @(negedge clk);
            if (stb) stbCnt++;
            @(posedge clk);
            #1;
            start = 1'b0;
            imm = immv;
        end
        checkOutput("func_stable", func, {32'h0, immv});
        ack = 1'b1; err = ackErr; ret = retv;
        @(posedge clk);
        #1;
        ack = 1'b0; err = 1'b0;
        @(negedge clk);
        checkOutput("done_timing", {63'h0, done}, 64'h1);
        checkOutput("stb_cycles", 64'(stbCnt), 64'(w));
    endtask

    task automatic runTimeout(input logic [31:0] immv, input logic [63:0] prevR0);
        exp_t e;
        int stbCnt;
        e.fault = 1'b1; e.code = 2'd2; e.we = 1'b0; e.r0 = prevR0;
        expQ.push_back(e);
        imm = immv; r1 = 64'h1; r2 = 64'h2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stbCnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) break;
            if (stb) stbCnt++;
            @(posedge clk);
            #1;
        end
        checkOutput("timeout_done", {63'h0, done}, 64'h1);
        checkOutput("timeout_stb_cycles", 64'(stbCnt), 64'd16);
        checkOutput("timeout_busy_low", {63'h0, busy}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", {63'h0, busy}, 64'h0);
        checkOutput("reset_stb", {63'h0, stb}, 64'h0);
        checkOutput("reset_done", {63'h0, done}, 64'h0);
        checkOutput("reset_func", func, 64'h0);
        checkOutput("reset_r0_out", r0_out, 64'h0);
        checkOutput("reset_fault_code", {62'h0, fault_code}, 64'h0);
        idle(1);

        $display("[TB] helper ff000001, minimum latency and one strobe cycle");
        applyStimulus(32'hff000001, 64'h5, 64'h0, 0, 1'b0, 64'h1, 1'b0, 2'd0, 1'b1, 64'h1, 1'b0);
        idle(2);
        applyStimulus(32'hff000001, 64'h5, 64'h0, 1, 1'b0, 64'h1, 1'b0, 2'd0, 1'b1, 64'h1, 1'b0);
        idle(2);

        $display("[TB] store then load");
        applyStimulus(32'hff000002, 64'h3, 64'hDEADBEEF, 3, 1'b0, 64'h0, 1'b0, 2'd0, 1'b1, 64'h0, 1'b0);
        idle(2);
        applyStimulus(32'hff000003, 64'h3, 64'h0, 2, 1'b0, 64'hDEADBEEF, 1'b0, 2'd0, 1'b1, 64'hDEADBEEF, 1'b0);
        idle(2);

        $display("[TB] unknown helper");
        applyStimulus(32'h12, 64'h0, 64'h0, 1, 1'b1, 64'h77, 1'b1, 2'd1, 1'b0, 64'hDEADBEEF, 1'b0);
        idle(1);
        checkOutput("fault_code_hold", {62'h0, fault_code}, 64'h1);
        idle(1);

        $display("[TB] timeout");
        runTimeout(32'hff000001, 64'hDEADBEEF);
        idle(2);

        $display("[TB] ack on the timeout cycle");
        applyStimulus(32'hff000001, 64'h9, 64'h0, 15, 1'b0, 64'hABCD, 1'b0, 2'd0, 1'b1, 64'hABCD, 1'b0);
        idle(2);

        $display("[TB] start during WAIT ignored");
        applyStimulus(32'hff000004, 64'h7, 64'h8, 3, 1'b0, 64'h1234, 1'b0, 2'd0, 1'b1, 64'h1234, 1'b1);
        idle(3);
        checkOutput("no_queued_start", {63'h0, busy}, 64'h0);

        $display("[TB] stray ack in IDLE");
        ack = 1'b1; ret = 64'h5555;
        idle(1);
        ack = 1'b0;
        idle(2);
        checkOutput("stray_ack_r0", r0_out, 64'h1234);
        checkOutput("stray_ack_busy", {63'h0, busy}, 64'h0);

        $display("[TB] reset mid-WAIT");
        imm = 32'h42; r1 = 64'h1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_stb", {63'h0, stb}, 64'h0);
        checkOutput("async_reset_busy", {63'h0, busy}, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        checkOutput("post_reset_func", func, 64'h0);
        checkOutput("post_reset_r0", r0_out, 64'h0);

        $display("[TB] back-to-back calls");
        applyStimulus(32'hff000001, 64'h1, 64'h0, 0, 1'b0, 64'h11, 1'b0, 2'd0, 1'b1, 64'h11, 1'b0);
        applyStimulus(32'hff000003, 64'h2, 64'h0, 1, 1'b0, 64'h22, 1'b0, 2'd0, 1'b1, 64'h22, 1'b0);
        idle(3);

        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
